// File: rtl/cordic_pkg.sv
// Shared types and default sizing for the CORDIC request scheduler.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_POINT_WIDTH = 16;
  localparam int DEF_ANGLE_WIDTH = 16;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int IDX_W = $clog2(N);

  logic               found;
  logic [IDX_W:0]     pos_sum;
  logic [IDX_W-1:0]   pos;

  // Walk the requesters starting at ptr and pick the first one asserted.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    pos_sum = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos_sum >= (IDX_W+1)'(N)) begin
        pos_sum = pos_sum - (IDX_W+1)'(N);
      end
      pos = pos_sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares a single iterative CORDIC core among NUM_REQ requesters: round-robin
// accept, one-cycle start pulse, watchdog-guarded wait for done, and a
// one-hot valid/ready response back to the requester that was granted.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int POINT_WIDTH = DEF_POINT_WIDTH,
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][POINT_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ-1:0][POINT_WIDTH-1:0]   req_y,
  input  logic [NUM_REQ-1:0][ANGLE_WIDTH-1:0]   req_z,
  output logic                                  core_start,
  output logic signed [POINT_WIDTH-1:0]         core_x,
  output logic signed [POINT_WIDTH-1:0]         core_y,
  output logic signed [ANGLE_WIDTH-1:0]         core_z,
  input  logic                                  core_done,
  input  logic signed [POINT_WIDTH-1:0]         core_x_out,
  input  logic signed [POINT_WIDTH-1:0]         core_y_out,
  input  logic signed [ANGLE_WIDTH-1:0]         core_z_out,
  output logic [NUM_REQ-1:0]                    resp_valid,
  input  logic [NUM_REQ-1:0]                    resp_ready,
  output logic signed [POINT_WIDTH-1:0]         resp_x,
  output logic signed [POINT_WIDTH-1:0]         resp_y,
  output logic signed [ANGLE_WIDTH-1:0]         resp_z,
  output logic                                  resp_err,
  output logic                                  busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_e                  state_q, state_d;
  logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]              gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]              wd_cnt_q, wd_cnt_d;
  logic signed [POINT_WIDTH-1:0] core_x_q, core_x_d;
  logic signed [POINT_WIDTH-1:0] core_y_q, core_y_d;
  logic signed [ANGLE_WIDTH-1:0] core_z_q, core_z_d;
  logic signed [POINT_WIDTH-1:0] resp_x_q, resp_x_d;
  logic signed [POINT_WIDTH-1:0] resp_y_q, resp_y_d;
  logic signed [ANGLE_WIDTH-1:0] resp_z_q, resp_z_d;
  logic                          resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]            arb_grant;
  logic [IDX_W-1:0]              arb_idx;
  logic                          accept;
  logic [CNT_W-1:0]              wd_cnt_inc;
  logic                          timeout_hit;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant)
  );

  // Encode the one-hot grant, and derive acceptance and watchdog expiry.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        arb_idx = IDX_W'(i);
      end
    end
    accept      = (state_q == IDLE) && (|(req_valid & arb_grant));
    wd_cnt_inc  = wd_cnt_q + 1'b1;
    timeout_hit = (wd_cnt_inc == CNT_W'(TIMEOUT));
  end

  // State, pointer, watchdog and operand/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      wd_cnt_q   <= '0;
      core_x_q   <= '0;
      core_y_q   <= '0;
      core_z_q   <= '0;
      resp_x_q   <= '0;
      resp_y_q   <= '0;
      resp_z_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      wd_cnt_q   <= wd_cnt_d;
      core_x_q   <= core_x_d;
      core_y_q   <= core_y_d;
      core_z_q   <= core_z_d;
      resp_x_q   <= resp_x_d;
      resp_y_q   <= resp_y_d;
      resp_z_q   <= resp_z_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Next-state logic; core_done is only looked at while waiting on the core.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    wd_cnt_d   = wd_cnt_q;
    core_x_d   = core_x_q;
    core_y_d   = core_y_q;
    core_z_d   = core_z_q;
    resp_x_d   = resp_x_q;
    resp_y_d   = resp_y_q;
    resp_z_d   = resp_z_q;
    resp_err_d = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_idx_d = arb_idx;
          core_x_d  = req_x[arb_idx];
          core_y_d  = req_y[arb_idx];
          core_z_d  = req_z[arb_idx];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        // Saturate rather than wrap so a late done can never alias a fresh count.
        if (wd_cnt_q != CNT_W'(TIMEOUT)) begin
          wd_cnt_d = wd_cnt_inc;
        end
        if (core_done) begin
          resp_x_d   = core_x_out;
          resp_y_d   = core_y_out;
          resp_z_d   = core_z_out;
          resp_err_d = 1'b0;
          state_d    = RESP;
        end else if (timeout_hit) begin
          resp_x_d   = '0;
          resp_y_d   = '0;
          resp_z_d   = '0;
          resp_err_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (resp_ready[gnt_idx_q]) begin
          rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and held registers.
  always_comb begin
    req_ready  = (state_q == IDLE) ? arb_grant : '0;
    core_start = (state_q == ISSUE);
    resp_valid = '0;
    if (state_q == RESP) begin
      resp_valid[gnt_idx_q] = 1'b1;
    end
    busy       = (state_q != IDLE);
    core_x     = core_x_q;
    core_y     = core_y_q;
    core_z     = core_z_q;
    resp_x     = resp_x_q;
    resp_y     = resp_y_q;
    resp_z     = resp_z_q;
    resp_err   = resp_err_q;
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler: requesters and a latency-programmable
// core model are driven from the main process; a monitor checks responses.
module tb_cordic_scheduler;

  localparam int N  = 4;
  localparam int PW = 16;
  localparam int AW = 16;
  localparam int TO = 64;

  typedef struct {
    int          idx;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [AW-1:0] z;
    int          lat;
    int          acc;
  } job_t;

  typedef struct {
    int          idx;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [AW-1:0] z;
    bit          err;
    int          acc;
    int          due;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0][PW-1:0]   req_x = '0;
  logic [N-1:0][PW-1:0]   req_y = '0;
  logic [N-1:0][AW-1:0]   req_z = '0;
  logic                   core_start;
  logic [PW-1:0]          core_x, core_y;
  logic [AW-1:0]          core_z;
  logic                   core_done = 1'b0;
  logic [PW-1:0]          core_x_out = '0, core_y_out = '0;
  logic [AW-1:0]          core_z_out = '0;
  logic [N-1:0]           resp_valid;
  logic [N-1:0]           resp_ready = '0;
  logic [PW-1:0]          resp_x, resp_y;
  logic [AW-1:0]          resp_z;
  logic                   resp_err;
  logic                   busy;

  cordic_scheduler #(
    .NUM_REQ(N), .POINT_WIDTH(PW), .ANGLE_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_done(core_done), .core_x_out(core_x_out), .core_y_out(core_y_out),
    .core_z_out(core_z_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_x(resp_x), .resp_y(resp_y), .resp_z(resp_z),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Requester model and reference state
  bit [N-1:0]    pend = '0;
  logic [PW-1:0] ox [N];
  logic [PW-1:0] oy [N];
  logic [AW-1:0] oz [N];
  int   exp_ptr = 0;
  bit   model_busy = 1'b0;
  int   idle_from = 0;
  int   n_acc = 0;
  int   grant_log [$];
  job_t job_q [$];
  exp_t exp_q [$];

  bit cont_mode = 0, rand_mode = 0, rr_rand = 0, lat_rand = 0;
  int lat_fixed = 4;
  int stray_req = 0, stray_done = 0;

  // Monitor bookkeeping
  bit            head_seen = 0;
  int            hold = 0, last_hold = 0, last_lat = 0;
  logic [PW-1:0] last_x = '0;
  logic          last_err = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
  endtask

  function automatic logic [PW-1:0] fx(input logic [PW-1:0] v); return v ^ 16'h5234; endfunction
  function automatic logic [PW-1:0] fy(input logic [PW-1:0] v); return v ^ 16'h0A5A; endfunction
  function automatic logic [AW-1:0] fz(input logic [AW-1:0] v); return v ^ 16'h3C3C; endfunction

  task automatic new_ops(input int i);
    ox[i] = PW'($urandom);
    oy[i] = PW'($urandom);
    oz[i] = AW'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_x[i] = ox[i];
      req_y[i] = oy[i];
      req_z[i] = oz[i];
    end
  endtask

  // Predict the grant from pending requests and the round-robin pointer.
  task automatic observe(output int acc_e);
    bit ready_expected;
    logic [N-1:0] want;
    int lat;
    job_t j;
    exp_t e;
    acc_e = -1;
    ready_expected = !model_busy && (cyc >= idle_from);
    if (ready_expected) begin
      for (int k = 0; k < N; k++) begin
        if (acc_e < 0 && pend[(exp_ptr + k) % N]) acc_e = (exp_ptr + k) % N;
      end
    end
    want = '0;
    if (acc_e >= 0) want[acc_e] = 1'b1;
    cmp("req_ready", req_ready, want);
    if (acc_e >= 0) begin
      if (lat_rand) begin
        case ($urandom_range(0, 9))
          0: lat = TO;
          1: lat = TO + 1;
          2: lat = -1;
          default: lat = int'($urandom_range(1, 12));
        endcase
      end else lat = lat_fixed;
      j.idx = acc_e; j.x = ox[acc_e]; j.y = oy[acc_e]; j.z = oz[acc_e];
      j.lat = lat; j.acc = cyc;
      job_q.push_back(j);
      e.idx = acc_e; e.acc = cyc;
      e.err = (lat < 0) || (lat > TO);
      e.x = e.err ? '0 : fx(j.x);
      e.y = e.err ? '0 : fy(j.y);
      e.z = e.err ? '0 : fz(j.z);
      e.due = cyc + (e.err ? TO + 2 : lat + 2);
      exp_q.push_back(e);
      grant_log.push_back(acc_e);
      model_busy = 1'b1;
      n_acc++;
    end
  endtask

  task automatic step();
    int acc_e;
    @(negedge clk);
    acc_e = -1;
    if (!rst) observe(acc_e);
    @(posedge clk);
    #1;
    if (acc_e >= 0) begin
      if (cont_mode) new_ops(acc_e);
      else pend[acc_e] = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          new_ops(i);
        end
      end
    end
    if (rr_rand) resp_ready = N'($urandom);
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    job_q.delete();
    model_busy = 1'b0;
    exp_ptr = 0;
    head_seen = 1'b0;
    repeat (n) step();
    rst = 1'b0;
    idle_from = cyc;
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge clk);
    cmp({tag, "_req_ready"}, req_ready, '0);
    cmp({tag, "_core_start"}, core_start, 0);
    cmp({tag, "_core_x"}, core_x, '0);
    cmp({tag, "_core_y"}, core_y, '0);
    cmp({tag, "_core_z"}, core_z, '0);
    cmp({tag, "_resp_valid"}, resp_valid, '0);
    cmp({tag, "_resp_x"}, resp_x, '0);
    cmp({tag, "_resp_y"}, resp_y, '0);
    cmp({tag, "_resp_z"}, resp_z, '0);
    cmp({tag, "_resp_err"}, resp_err, 0);
    cmp({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int maxc);
    int n = 0;
    while (n_acc < target && n < maxc) begin step(); n++; end
    if (n >= maxc) cmp("accept_bound", n_acc, target);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((model_busy || exp_q.size() != 0) && n < maxc) begin step(); n++; end
    if (n >= maxc) cmp("drain_bound", exp_q.size(), 0);
  endtask

  // Core model: done arrives a programmed number of cycles after start.
  initial begin : core_model
    job_t j;
    int cd;
    logic [PW-1:0] cx, cy;
    logic [AW-1:0] cz;
    cd = -1; cx = '0; cy = '0; cz = '0;
    forever begin
      @(negedge clk);
      if (rst) cd = -1;
      else if (core_start === 1'b1) begin
        if (job_q.size() == 0) cmp("core_start_unexpected", core_start, 0);
        else begin
          j = job_q.pop_front();
          cmp("core_start_cycle", cyc, j.acc + 1);
          cmp("core_x", core_x, j.x);
          cmp("core_y", core_y, j.y);
          cmp("core_z", core_z, j.z);
          cd = j.lat; cx = j.x; cy = j.y; cz = j.z;
        end
      end
      @(posedge clk);
      #1;
      core_done = 1'b0;
      core_x_out = PW'($urandom);
      core_y_out = PW'($urandom);
      core_z_out = AW'($urandom);
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        core_done = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1;
          core_x_out = fx(cx);
          core_y_out = fy(cy);
          core_z_out = fz(cz);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each response handshake.
  always @(negedge clk) begin : resp_monitor
    exp_t e;
    logic [N-1:0] oh;
    if (!rst && resp_valid != '0) begin
      if (exp_q.size() == 0) cmp("resp_unexpected", resp_valid, '0);
      else begin
        e = exp_q[0];
        if (!head_seen) begin
          head_seen = 1'b1;
          hold = 0;
          cmp("resp_latency", cyc - e.acc, e.due - e.acc);
        end
        hold++;
        oh = '0;
        oh[e.idx] = 1'b1;
        cmp("resp_index", resp_valid, oh);
        cmp("resp_x", resp_x, e.x);
        cmp("resp_y", resp_y, e.y);
        cmp("resp_z", resp_z, e.z);
        cmp("resp_err", resp_err, e.err);
        cmp("req_ready_in_resp", req_ready, '0);
        cmp("busy_in_resp", busy, 1);
        if (resp_ready[e.idx]) begin
          void'(exp_q.pop_front());
          head_seen = 1'b0;
          last_x = resp_x;
          last_err = resp_err;
          last_lat = cyc - e.acc;
          last_hold = hold;
          exp_ptr = (e.idx + 1) % N;
          model_busy = 1'b0;
          idle_from = cyc + 1;
        end
      end
    end else if (!rst && exp_q.size() != 0 && !head_seen && cyc > exp_q[0].due) begin
      cmp("resp_missing", cyc, exp_q[0].due);
      head_seen = 1'b1;
    end
  end

  initial begin : main
    int n;
    for (int i = 0; i < N; i++) begin ox[i] = '0; oy[i] = '0; oz[i] = '0; end
    do_reset(3);
    chk_idle_outputs("reset");

    // All requesters valid back to back: strict rotation from index 0.
    resp_ready = '1;
    lat_fixed = 3;
    cont_mode = 1;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; new_ops(i); end
    drive();
    grant_log.delete();
    wait_acc(n_acc + 5, 200);
    cont_mode = 0;
    pend = '0;
    drive();
    wait_drain(100);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) cmp("rr_order", grant_log[k], k % N);
    end

    // Single request with fixed operands and latency 16.
    lat_fixed = 16;
    pend[0] = 1'b1; ox[0] = 16'h4000; oy[0] = 16'h0000; oz[0] = 16'h2000;
    drive();
    wait_acc(n_acc + 1, 50);
    wait_drain(100);
    cmp("single_x", last_x, 16'h1234);
    cmp("single_err", last_err, 0);
    cmp("single_lat", last_lat, 18);

    // Backpressure: response held for five extra cycles.
    resp_ready = '0;
    lat_fixed = 5;
    pend[2] = 1'b1; new_ops(2);
    drive();
    n = 0;
    while (resp_valid == '0 && n < 100) begin step(); n++; end
    if (n >= 100) cmp("bp_resp_bound", resp_valid, 4'b0100);
    repeat (5) step();
    resp_ready = '1;
    wait_drain(50);
    cmp("bp_hold_cycles", last_hold, 6);

    // Core never answers: watchdog error response.
    lat_fixed = -1;
    pend[1] = 1'b1; new_ops(1);
    drive();
    wait_acc(n_acc + 1, 50);
    wait_drain(200);
    cmp("timeout_err", last_err, 1);
    cmp("timeout_lat", last_lat, TO + 2);

    // Reset while waiting on the core, then a stray done.
    pend[2] = 1'b1; new_ops(2);
    drive();
    wait_acc(n_acc + 1, 50);
    repeat (5) step();
    do_reset(1);
    stray_req++;
    repeat (3) step();
    chk_idle_outputs("midrst");
    lat_fixed = 2;
    pend[0] = 1'b1; new_ops(0);
    pend[3] = 1'b1; new_ops(3);
    drive();
    wait_acc(n_acc + 1, 20);
    cmp("post_reset_grant", grant_log[grant_log.size() - 1], 0);
    wait_drain(50);
    wait_acc(n_acc + 1, 20);
    wait_drain(50);

    // Done on the exact cycle the watchdog would expire: data wins.
    lat_fixed = TO;
    pend[3] = 1'b1; new_ops(3);
    drive();
    wait_acc(n_acc + 1, 50);
    wait_drain(200);
    cmp("coincide_err", last_err, 0);
    cmp("coincide_lat", last_lat, TO + 2);

    // Random traffic, latencies and response backpressure.
    lat_rand = 1;
    rand_mode = 1;
    rr_rand = 1;
    wait_acc(n_acc + 30, 20000);
    rand_mode = 0;
    rr_rand = 0;
    pend = '0;
    resp_ready = '1;
    drive();
    wait_drain(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_scheduler.md
# cordic_scheduler

Shares one iterative CORDIC core among `NUM_REQ` requesters. It arbitrates requests round-robin and captures the operands of the winner. It then pulses the core's start, waits for done (with a watchdog) and returns the result on a per-requester valid/ready response channel. The block sits between client blocks and the single CORDIC instance; only one job is in flight at a time.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `POINT_WIDTH`, 16: x/y operand and result width, signed.
- `ANGLE_WIDTH`, 16: z operand and result width, signed.
- `TIMEOUT`, 64: max cycles from `core_start` to `core_done` before an error response.

Clock and reset are decided: one clock; reset is synchronous and active-high.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in NUM_REQ: request pending, per requester.
- `req_ready` out NUM_REQ: one-hot grant, combinational; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_x`, `req_y` in NUM_REQ×POINT_WIDTH: per-requester operands.
- `req_z` in NUM_REQ×ANGLE_WIDTH: per-requester angle operand.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_x`, `core_y` out POINT_WIDTH: operands, held stable from ISSUE through WAIT.
- `core_z` out ANGLE_WIDTH: angle operand, held stable from ISSUE through WAIT.
- `core_done` in 1: core result valid, one-cycle pulse.
- `core_x_out`, `core_y_out` in POINT_WIDTH: core results, sampled on `core_done`.
- `core_z_out` in ANGLE_WIDTH: core result, sampled on `core_done`.
- `resp_valid` out NUM_REQ: one-hot, result for requester i.
- `resp_ready` in NUM_REQ: requester accepts the result.
- `resp_x`, `resp_y` out POINT_WIDTH: shared result bus.
- `resp_z` out ANGLE_WIDTH: shared result bus.
- `resp_err` out 1: qualifies `resp_valid`; 1 means watchdog expired and the data is zero.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` = one-hot grant of the lowest index ≥ `rr_ptr` with `req_valid` set, wrapping modulo NUM_REQ. It is all-zero if no request is pending.
  - On acceptance: latch grant index `g`, latch its operands into the core operand registers, go to ISSUE.
- **ISSUE**
  - `core_start`=1 for exactly this cycle.
  - Watchdog counter is cleared.
  - Go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `core_done`: capture core results into `resp_*`, set `resp_err`=0, go to RESP.
  - Else, when counter reaches TIMEOUT: set `resp_*` to 0, set `resp_err`=1, go to RESP.
  - If `core_done` and timeout occur in the same cycle, `core_done` wins.
- **RESP**
  - `resp_valid[g]`=1; data is held until `resp_ready[g]`.
  - On handshake: `rr_ptr` ← (g+1) mod NUM_REQ, go to IDLE.
  - `resp_ready` of other indices is ignored.
- `core_done` outside WAIT is ignored.
- `req_ready` is 0 in every state except IDLE.
- Watchdog width is $clog2(TIMEOUT+1); it does not wrap.
- Operands and results pass through unmodified; no arithmetic is performed in this block.

## Timing
- Reset values:
  - `req_ready`=0, `core_start`=0, `core_x/y/z`=0.
  - `resp_valid`=0, `resp_x/y/z`=0, `resp_err`=0, `busy`=0.
  - state=IDLE, `rr_ptr`=0, counter=0.
- Accept at cycle 0, `core_start` at cycle 1.
- `core_done` at cycle 1+L gives `resp_valid` at cycle 2+L.
- With `resp_ready` held high, the next accept is possible at cycle 3+L.
- Throughput: one job per L+3 cycles at best.
- Timeout path: `resp_valid` with `resp_err` appears TIMEOUT+2 cycles after accept.
- Reset mid-operation (any state):
  - Return to IDLE with reset values in the next cycle.
  - The in-flight job is dropped; no response is issued.
  - A later stray `core_done` is ignored.

## Structure
- `cordic_pkg`: `sched_state_e` enum (IDLE, ISSUE, WAIT, RESP), default width localparams.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`; output one-hot `grant`; purely combinational.
- `cordic_scheduler` holds the FSM, `rr_ptr`, watchdog, and operand/result registers.

## Test plan
- Single request: `req_valid`=4'b0001, x=16'h4000, y=0, z=16'h2000; core model with L=16 returns x=16'h1234 → `core_start` at cycle 1, `resp_valid`=4'b0001 at cycle 18 with `resp_x`=16'h1234, `resp_err`=0.
- All four requesters valid continuously → grants are 0,1,2,3,0 in order; responses return to the matching index.
- Response backpressure: `resp_ready` low for 5 cycles → `resp_valid` and data stable for 5 cycles; `req_ready`=0 throughout.
- Core never asserts done, TIMEOUT=64 → `resp_err`=1 with zero data 66 cycles after accept; `rr_ptr` advances.
- `rst` asserted in WAIT, then stray `core_done` → no `resp_valid`; all outputs at reset values; next request granted from index 0.
- Done and timeout coincide → data response with `resp_err`=0.
